// File: rtl/ex_div_stall_requester_if.sv
// Handshake bundle between the EX-stage instruction logic and the multi-cycle divider.
// The divider takes the slave modport; whoever issues DIV/DIVU and consumes the result takes master.
interface ex_div_stall_requester_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output start_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output annul_i,
        input  result_o,
        input  ready_o,
        input  stallreq_o
    );

    modport slave (
        input  start_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  annul_i,
        output result_o,
        output ready_o,
        output stallreq_o
    );
endinterface

// File: rtl/ex_div_stall_requester.sv
// Radix-2 restoring divider for the EX stage that holds stallreq_o high while a DIV/DIVU is in flight.
// Optional macro DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module ex_div_stall_requester #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    ex_div_stall_requester_if.slave    div_if
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [WIDTH-1:0]     dvd_q;
    logic [WIDTH-1:0]     dvs_q;
    logic [WIDTH-1:0]     rem_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_quot_q;
    logic                 neg_rem_q;
    logic [2*WIDTH-1:0]   result_q;

    logic                 start_ok;
    logic                 divisor_zero;
    logic                 early_exit;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       diff;
    logic                 fits;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quot_step;
    logic [WIDTH-1:0]     rem_fixed;
    logic [WIDTH-1:0]     quot_fixed;
    logic                 last_step;
    logic                 ready;
    logic                 stallreq;

    assign start_ok     = div_if.start_i && !div_if.annul_i;
    assign divisor_zero = (div_if.opdata2_i == '0);

    // Magnitudes only for DIV; the most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign abs_a = (div_if.signed_div_i && div_if.opdata1_i[WIDTH-1]) ? (WIDTH'(0) - div_if.opdata1_i)
                                                                     : div_if.opdata1_i;
    assign abs_b = (div_if.signed_div_i && div_if.opdata2_i[WIDTH-1]) ? (WIDTH'(0) - div_if.opdata2_i)
                                                                     : div_if.opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = !divisor_zero && (abs_a < abs_b);
`else
    assign early_exit = 1'b0;
`endif

    // One restoring step: the dividend register shifts out its MSB and shifts in the new quotient bit.
    assign rem_shift  = {rem_q, dvd_q[WIDTH-1]};
    assign diff       = rem_shift - {1'b0, dvs_q};
    assign fits       = !diff[WIDTH];
    assign rem_step   = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quot_step  = {dvd_q[WIDTH-2:0], fits};
    assign rem_fixed  = neg_rem_q  ? (WIDTH'(0) - rem_step)  : rem_step;
    assign quot_fixed = neg_quot_q ? (WIDTH'(0) - quot_step) : quot_step;
    assign last_step  = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stall is combinational so an annul releases the pipeline in the same cycle it arrives.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        stallreq   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    stallreq = 1'b1;
                    if (divisor_zero) begin
                        state_next = S_BYZERO;
                    end else if (early_exit) begin
                        state_next = S_END;
                    end else begin
                        state_next = S_ON;
                    end
                end
            end
            S_BYZERO: begin
                if (div_if.annul_i) begin
                    state_next = S_IDLE;
                end else begin
                    stallreq   = 1'b1;
                    state_next = S_END;
                end
            end
            S_ON: begin
                if (div_if.annul_i) begin
                    state_next = S_IDLE;
                end else begin
                    stallreq = 1'b1;
                    if (last_step) begin
                        state_next = S_END;
                    end
                end
            end
            S_END: begin
                ready      = !div_if.annul_i;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (rst) begin
            state_next = S_IDLE;
            ready      = 1'b0;
            stallreq   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        dvd_q      <= abs_a;
                        dvs_q      <= abs_b;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        neg_quot_q <= div_if.signed_div_i &&
                                      (div_if.opdata1_i[WIDTH-1] ^ div_if.opdata2_i[WIDTH-1]);
                        neg_rem_q  <= div_if.signed_div_i && div_if.opdata1_i[WIDTH-1];
                        if (!divisor_zero && early_exit) begin
                            result_q <= {div_if.opdata1_i, {WIDTH{1'b0}}};
                        end
                    end
                end
                S_BYZERO: begin
                    if (!div_if.annul_i) begin
                        result_q <= '0;
                    end
                end
                S_ON: begin
                    if (!div_if.annul_i) begin
                        rem_q <= rem_step;
                        dvd_q <= quot_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_step) begin
                            result_q <= {rem_fixed, quot_fixed};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_if.result_o   = result_q;
    assign div_if.ready_o    = ready;
    assign div_if.stallreq_o = stallreq;

endmodule
